mem_port_arbiter: RTL and testbench

Three-way arbiter and access sequencer for the multi-cycle CPU's shared 32-word instruction/data memory. It serialises instruction fetch, data load/store and program-loader writes onto the memory's single port. Each access runs through a fixed three-state sequence with a req/done handshake per requester. It sits between the control unit/datapath and the memory, and is the only block that drives the memory's address, write-data and write-enable inputs.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter and access sequencer for the shared instruction/data memory.
// Each access runs IDLE -> ACCESS -> RESP; the loader has fixed priority, fetch/data alternate.
module mem_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic              f_err,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_done,
  output logic              l_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0]  G_NONE  = 2'b00;
  localparam logic [1:0]  G_FETCH = 2'b01;
  localparam logic [1:0]  G_DATA  = 2'b10;
  localparam logic [1:0]  G_LOAD  = 2'b11;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t              r_state;
  logic                r_last_data;
  logic                r_oor;
  logic [1:0]          r_grant;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_write;
  logic                r_f_done, r_f_err, r_d_done, r_d_err, r_l_done, r_l_err;
  logic [DATA_W-1:0]   r_f_rdata, r_d_rdata;

  logic [1:0]          w_win;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_wflag;
  logic                w_in_range;

  // On a fetch/data tie, data wins unless data was the last of the two granted.
  always_comb begin
    w_win = G_NONE;
    if (l_req)
      w_win = G_LOAD;
    else if (d_req && (!f_req || !r_last_data))
      w_win = G_DATA;
    else if (f_req)
      w_win = G_FETCH;
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_wflag = 1'b0;
    case (w_win)
      G_FETCH: w_addr = f_addr;
      G_DATA: begin
        w_addr  = d_addr;
        w_wdata = d_wdata;
        w_wflag = d_we;
      end
      G_LOAD: begin
        w_addr  = l_addr;
        w_wdata = l_wdata;
        w_wflag = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_in_range = 32'(w_addr) < DEPTH_U;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_data <= 1'b0;
      r_oor       <= 1'b0;
      r_grant     <= G_NONE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_write <= 1'b0;
      r_f_done    <= 1'b0;
      r_f_err     <= 1'b0;
      r_d_done    <= 1'b0;
      r_d_err     <= 1'b0;
      r_l_done    <= 1'b0;
      r_l_err     <= 1'b0;
      r_f_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win != G_NONE) begin
            r_state     <= ACCESS;
            r_grant     <= w_win;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_mem_write <= w_wflag && w_in_range;
            r_oor       <= !w_in_range;
            if (w_win == G_FETCH)
              r_last_data <= 1'b0;
            else if (w_win == G_DATA)
              r_last_data <= 1'b1;
          end
        end
        ACCESS: begin
          // The memory commits the write on this edge; read data is the pre-write word.
          r_state     <= RESP;
          r_mem_write <= 1'b0;
          case (r_grant)
            G_FETCH: begin
              r_f_done  <= 1'b1;
              r_f_err   <= r_oor;
              r_f_rdata <= r_oor ? '0 : mem_rdata;
            end
            G_DATA: begin
              r_d_done  <= 1'b1;
              r_d_err   <= r_oor;
              r_d_rdata <= r_oor ? '0 : mem_rdata;
            end
            G_LOAD: begin
              r_l_done <= 1'b1;
              r_l_err  <= r_oor;
            end
            default: ;
          endcase
        end
        RESP: begin
          r_state  <= IDLE;
          r_grant  <= G_NONE;
          r_f_done <= 1'b0;
          r_f_err  <= 1'b0;
          r_d_done <= 1'b0;
          r_d_err  <= 1'b0;
          r_l_done <= 1'b0;
          r_l_err  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign f_done    = r_f_done;
  assign f_err     = r_f_err;
  assign f_rdata   = r_f_rdata;
  assign d_done    = r_d_done;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;
  assign l_done    = r_l_done;
  assign l_err     = r_l_err;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_write = r_mem_write;
  assign grant_id  = r_grant;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: 32-word memory model, transaction-level reference
// model (priority rules + shadow memory), directed test-plan steps then random traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_we, l_req;
  logic [5:0]  f_addr, d_addr, l_addr;
  logic [31:0] d_wdata, l_wdata;
  logic        f_done, f_err, d_done, d_err, l_done, l_err;
  logic [31:0] f_rdata, d_rdata;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_write, busy;
  logic [1:0]  grant_id;

  logic [31:0] mem [0:31];

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_tx    = 0;
  logic [31:0] ref_mem [0:31];
  bit          m_last_data;
  logic [31:0] exp_f, exp_d;
  int          last_w;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done), .l_err(l_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_write && mem_addr < 6'd32) mem[mem_addr[4:0]] <= mem_wdata;

  assign mem_rdata = (mem_addr < 6'd32) ? mem[mem_addr[4:0]] : 32'ha5a5a5a5;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mw"}, mem_write, 0);
    chk({tag, "_ma"}, mem_addr, 0);
    chk({tag, "_mwd"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant_id, 0);
    chk({tag, "_done"}, {f_done, d_done, l_done, f_err, d_err, l_err}, 0);
    chk({tag, "_frd"}, f_rdata, 0);
    chk({tag, "_drd"}, d_rdata, 0);
  endtask

  // One complete access: choose the winner from the arbitration rules, then check
  // the ACCESS, RESP and following IDLE cycles.
  task automatic serve_one();
    int          w;
    logic [5:0]  addr;
    logic [31:0] wd, old;
    bit          wr, inr;
    if (l_req) w = 3;
    else if (f_req && d_req) w = m_last_data ? 1 : 2;
    else if (d_req) w = 2;
    else w = 1;
    if (w == 1) m_last_data = 0;
    else if (w == 2) m_last_data = 1;
    addr = (w == 1) ? f_addr : (w == 2) ? d_addr : l_addr;
    wd   = (w == 2) ? d_wdata : l_wdata;
    wr   = (w == 3) || (w == 2 && d_we);
    inr  = addr < 6'd32;
    last_w = w;

    @(posedge clk); @(negedge clk);
    chk("acc_busy", busy, 1);
    chk("acc_grant", grant_id, w);
    chk("acc_we", mem_write, wr && inr);
    chk("acc_addr", mem_addr, addr);
    if (wr) chk("acc_wdata", mem_wdata, wd);
    chk("acc_done", {f_done, d_done, l_done}, 0);

    @(posedge clk); @(negedge clk);
    old = inr ? ref_mem[addr[4:0]] : 32'h0;
    if (wr && inr) ref_mem[addr[4:0]] = wd;
    if (w == 1) exp_f = old;
    if (w == 2) exp_d = old;
    chk("resp_done", {f_done, d_done, l_done}, {w == 1, w == 2, w == 3});
    chk("resp_err", {f_err, d_err, l_err}, {w == 1 && !inr, w == 2 && !inr, w == 3 && !inr});
    chk("resp_frdata", f_rdata, exp_f);
    chk("resp_drdata", d_rdata, exp_d);
    chk("resp_we", mem_write, 0);
    chk("resp_grant", grant_id, w);
    chk("resp_busy", busy, 1);
    n_tx++;
    $display("txn %0d: grant=%0d addr=%0d write=%0b err=%0b rdata=%h",
             n_tx, w, addr, wr, !inr, old);
    if (w == 1) f_req = 0;
    else if (w == 2) d_req = 0;
    else l_req = 0;

    @(posedge clk); @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant_id, 0);
    chk("idle_done", {f_done, d_done, l_done, f_err, d_err, l_err}, 0);
  endtask

  task automatic serve_all();
    for (int k = 0; k < 4 && (f_req || d_req || l_req); k++) serve_one();
  endtask

  initial begin
    rst = 1; f_req = 0; d_req = 0; l_req = 0; d_we = 0;
    f_addr = 0; d_addr = 0; l_addr = 0; d_wdata = 0; l_wdata = 0;
    m_last_data = 0; exp_f = 0; exp_d = 0; last_w = 0;
    #1 chk_reset_outputs("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst_clk");
    rst = 0;

    for (int i = 0; i < 32; i++) begin
      l_req = 1; l_addr = 6'(i);
      l_wdata = (i == 1) ? 32'h8c640000 : (i == 3) ? 32'h11111111 : $urandom;
      serve_one();
    end

    f_req = 1; f_addr = 1;
    serve_one();
    chk("single_fetch", f_rdata, 32'h8c640000);

    d_req = 1; d_we = 1; d_addr = 5; d_wdata = 32'hdeadbeef;
    serve_one();
    f_req = 1; f_addr = 5;
    serve_one();
    chk("store_fetch", f_rdata, 32'hdeadbeef);

    l_req = 1; l_addr = 7; l_wdata = 32'hcafef00d;
    d_req = 1; d_we = 0; d_addr = 2;
    f_req = 1; f_addr = 7;
    for (int i = 0; i < 3; i++) begin
      serve_one();
      chk("prec_order", last_w, 3 - i);
    end
    chk("prec_fetch", f_rdata, 32'hcafef00d);

    d_req = 1; d_we = 1; d_addr = 40; d_wdata = 32'h5a5a5a5a;
    serve_one();
    chk("oor_rdata", d_rdata, 0);
    for (int i = 0; i < 32; i++) chk("oor_mem", mem[i], ref_mem[i]);

    d_req = 1; d_we = 1; d_addr = 3; d_wdata = 32'h22222222;
    @(posedge clk); @(negedge clk);
    chk("rstmid_we", mem_write, 1);
    #1 rst = 1;
    #1 chk_reset_outputs("rstmid");
    d_req = 0;
    @(posedge clk); @(negedge clk);
    rst = 0;
    m_last_data = 0; exp_f = 0; exp_d = 0;
    chk("rstmid_mem3", mem[3], 32'h11111111);
    f_req = 1; f_addr = 3;
    serve_one();
    chk("rstmid_fetch", f_rdata, 32'h11111111);

    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    m_last_data = 0; exp_f = 0; exp_d = 0;
    d_we = 0; d_addr = 9; f_addr = 10;
    for (int i = 0; i < 4; i++) begin
      f_req = 1; d_req = 1;
      serve_one();
      chk("rr_order", last_w, (i % 2 == 0) ? 2 : 1);
    end
    f_req = 0; d_req = 0;

    for (int i = 0; i < 40; i++) begin
      f_req = 1'($urandom_range(0, 1));
      d_req = 1'($urandom_range(0, 1));
      l_req = 1'($urandom_range(0, 3) == 0);
      f_addr = 6'($urandom_range(0, 39));
      d_addr = 6'($urandom_range(0, 39));
      l_addr = 6'($urandom_range(0, 39));
      d_we = 1'($urandom_range(0, 1));
      d_wdata = $urandom; l_wdata = $urandom;
      if (!(f_req || d_req || l_req)) begin
        @(posedge clk); @(negedge clk);
        chk("rand_idle", {busy, grant_id}, 0);
      end
      serve_all();
    end
    for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
